// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter request arbiter.
// CNT_ARB_WRAP_EN (optional) turns off the saturation check so the counter wraps.
package cnt_arb_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MIN = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // True when the requested step would leave the counter's range.
  function automatic logic at_boundary(input logic [CNT_W-1:0] value, input logic down);
    return down ? (value == CNT_MIN) : (value == CNT_MAX);
  endfunction

endpackage

// File: rtl/cnt_req_arb_if.sv
// Request/response and counter-control bundle between the requesters, the arbiter
// and the shared up/down counter.
interface cnt_req_arb_if;
  import cnt_arb_pkg::*;

  logic [1:0]       req;
  logic [1:0]       dir;
  logic [CNT_W-1:0] cnt;
  logic             en;
  logic             dwn;
  logic [1:0]       ack;
  logic [1:0]       nack;
  logic             busy;

  modport master (
    output req, dir, cnt,
    input  en, dwn, ack, nack, busy
  );

  modport slave (
    input  req, dir, cnt,
    output en, dwn, ack, nack, busy
  );

endinterface

// File: rtl/cnt_req_arb_rr_arb2.sv
// Two-way round-robin selector: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/cnt_req_arb.sv
// Arbitrates two requesters onto one shared 4-bit up/down counter (IDLE/ISSUE/RESP).
// CNT_ARB_WRAP_EN: when defined, boundary refusal is removed and the counter wraps.
module cnt_req_arb
  import cnt_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  cnt_req_arb_if.slave   bus
);

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   dir_q, dir_d;
  logic   refused_q, refused_d;
  logic   last_q, last_d;
  logic   rr_grant, rr_valid;
  logic   blocked;
  logic   en_c, dwn_c, busy_c;
  logic [1:0] ack_c, nack_c;

  rr_arb2 u_rr (
    .req   (bus.req),
    .last  (last_q),
    .grant (rr_grant),
    .valid (rr_valid)
  );

`ifdef CNT_ARB_WRAP_EN
  assign blocked = 1'b0;
`else
  assign blocked = at_boundary(bus.cnt, dir_q);
`endif

  // last_q resets to requester 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      dir_q     <= 1'b0;
      refused_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      dir_q     <= dir_d;
      refused_q <= refused_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    dir_d     = dir_q;
    refused_d = refused_q;
    last_d    = last_q;
    en_c      = 1'b0;
    dwn_c     = 1'b0;
    ack_c     = 2'b00;
    nack_c    = 2'b00;
    busy_c    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          dir_d   = bus.dir[rr_grant];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        en_c      = ~blocked;
        dwn_c     = ~blocked & dir_q;
        refused_d = blocked;
        state_d   = RESP;
      end
      RESP: begin
        if (refused_q) begin
          nack_c[grant_q] = 1'b1;
        end else begin
          ack_c[grant_q] = 1'b1;
        end
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.en   = en_c;
  assign bus.dwn  = dwn_c;
  assign bus.ack  = ack_c;
  assign bus.nack = nack_c;
  assign bus.busy = busy_c;

endmodule

// File: tb/tb_cnt_req_arb.sv
// Directed, table-driven bench for cnt_req_arb with a behavioural shared counter.
// Expected values follow CNT_ARB_WRAP_EN when it is defined for the build.
module tb_cnt_req_arb;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt_m;
  int         checks;
  int         errors;

  cnt_req_arb_if bus ();

  cnt_req_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: loadable by the bench, otherwise stepped by en/dwn.
  always @(posedge clk) begin
    if (load) begin
      cnt_m <= load_val;
    end else if (bus.en) begin
      cnt_m <= bus.dwn ? cnt_m - 4'd1 : cnt_m + 4'd1;
    end
  end

  assign bus.cnt = cnt_m;

  typedef struct {
    string      name;
    logic [1:0] req;
    logic [1:0] dir;
    logic [3:0] cnt;
    logic       en;
    logic       dwn;
    logic [1:0] ack;
    logic [1:0] nack;
    logic [3:0] cnt_after;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadCnt(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  // One complete operation from IDLE: ISSUE checks, RESP checks, then counter value.
  task automatic applyStimulus(input vec_t v);
    loadCnt(v.cnt);
    bus.req = v.req;
    bus.dir = v.dir;
    step();
    checkOutput({v.name, ".en"},   {7'd0, bus.en},   {7'd0, v.en});
    checkOutput({v.name, ".dwn"},  {7'd0, bus.dwn},  {7'd0, v.dwn});
    checkOutput({v.name, ".busy"}, {7'd0, bus.busy}, 8'd1);
    bus.req = 2'b00;
    step();
    checkOutput({v.name, ".ack"},  {6'd0, bus.ack},  {6'd0, v.ack});
    checkOutput({v.name, ".nack"}, {6'd0, bus.nack}, {6'd0, v.nack});
    checkOutput({v.name, ".en_resp"}, {7'd0, bus.en}, 8'd0);
    step();
    checkOutput({v.name, ".cnt"},  {4'd0, cnt_m},    {4'd0, v.cnt_after});
    checkOutput({v.name, ".idle"}, {7'd0, bus.busy}, 8'd0);
  endtask

  initial begin
    logic [1:0] exp_ack;
    int         wait_n;

    checks   = 0;
    errors   = 0;
    load     = 1'b0;
    load_val = 4'h0;
    bus.req  = 2'b00;
    bus.dir  = 2'b00;
    rst_n    = 1'b0;

    vecs[0] = '{"up3",      2'b01, 2'b00, 4'h3, 1'b1, 1'b0, 2'b01, 2'b00, 4'h4};
    vecs[1] = '{"down4",    2'b10, 2'b10, 4'h4, 1'b1, 1'b1, 2'b10, 2'b00, 4'h3};
    vecs[2] = '{"both_r0",  2'b11, 2'b01, 4'h7, 1'b1, 1'b1, 2'b01, 2'b00, 4'h6};
    vecs[3] = '{"both_r1",  2'b11, 2'b01, 4'h6, 1'b1, 1'b0, 2'b10, 2'b00, 4'h7};
`ifdef CNT_ARB_WRAP_EN
    vecs[4] = '{"upF",      2'b10, 2'b00, 4'hF, 1'b1, 1'b0, 2'b10, 2'b00, 4'h0};
    vecs[5] = '{"down0",    2'b01, 2'b01, 4'h0, 1'b1, 1'b1, 2'b01, 2'b00, 4'hF};
`else
    vecs[4] = '{"upF",      2'b10, 2'b00, 4'hF, 1'b0, 1'b0, 2'b00, 2'b10, 4'hF};
    vecs[5] = '{"down0",    2'b01, 2'b01, 4'h0, 1'b0, 1'b0, 2'b00, 2'b01, 4'h0};
`endif
    vecs[6] = '{"up0",      2'b10, 2'b00, 4'h0, 1'b1, 1'b0, 2'b10, 2'b00, 4'h1};
    vecs[7] = '{"downF",    2'b01, 2'b01, 4'hF, 1'b1, 1'b1, 2'b01, 2'b00, 4'hE};

    #12;
    checkOutput("rst.en",   {7'd0, bus.en},   8'd0);
    checkOutput("rst.dwn",  {7'd0, bus.dwn},  8'd0);
    checkOutput("rst.ack",  {6'd0, bus.ack},  8'd0);
    checkOutput("rst.nack", {6'd0, bus.nack}, 8'd0);
    checkOutput("rst.busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Contention from reset: req=11 held, grants alternate starting with requester 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    loadCnt(4'h5);
    bus.req = 2'b11;
    bus.dir = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_n  = 0;
      do begin
        step();
        wait_n++;
      end while (bus.ack == 2'b00 && bus.nack == 2'b00 && wait_n < 10);
      checkOutput($sformatf("rr.ack%0d", k), {6'd0, bus.ack}, {6'd0, exp_ack});
      checkOutput($sformatf("rr.gap%0d", k), wait_n[7:0], (k == 0) ? 8'd2 : 8'd3);
    end
    bus.req = 2'b00;
    step();
    checkOutput("rr.cnt", {4'd0, cnt_m}, 8'h09);

    // Mid-operation reset restores the requester-0 preference.
    loadCnt(4'h2);
    bus.req = 2'b01;
    step();
    step();
    bus.req = 2'b00;
    step();
    checkOutput("mid.pre_cnt", {4'd0, cnt_m}, 8'h03);
    bus.req = 2'b10;
    step();
    checkOutput("mid.issue_en", {7'd0, bus.en}, 8'd1);
    bus.req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid.en",   {7'd0, bus.en},   8'd0);
    checkOutput("mid.busy", {7'd0, bus.busy}, 8'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput($sformatf("mid.resp%0d", k), {4'd0, bus.ack, bus.nack}, 8'd0);
    end
    checkOutput("mid.cnt", {4'd0, cnt_m}, 8'h03);
    rst_n   = 1'b1;
    bus.req = 2'b11;
    bus.dir = 2'b00;
    step();
    bus.req = 2'b00;
    step();
    checkOutput("mid.first_grant", {6'd0, bus.ack}, 8'h01);
    step();
    checkOutput("mid.post_cnt", {4'd0, cnt_m}, 8'h04);

    // Input churn during ISSUE must not disturb the latched operation.
    loadCnt(4'h8);
    bus.req = 2'b10;
    bus.dir = 2'b10;
    step();
    bus.req = 2'b00;
    bus.dir = 2'b00;
    #1;
    checkOutput("churn.en",  {7'd0, bus.en},  8'd1);
    checkOutput("churn.dwn", {7'd0, bus.dwn}, 8'd1);
    bus.req = 2'b01;
    bus.dir = 2'b01;
    step();
    bus.req = 2'b00;
    checkOutput("churn.ack",  {6'd0, bus.ack},  8'h02);
    checkOutput("churn.nack", {6'd0, bus.nack}, 8'h00);
    step();
    checkOutput("churn.cnt",  {4'd0, cnt_m},    8'h07);
    checkOutput("churn.idle", {7'd0, bus.busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
